// File: rtl/instr_encoder.sv
// Encodes ADD/SUB/ADDI/BNE/JAL requests into RV32I words and streams them into instruction memory.
// One request per cycle in LOAD; writes appear one cycle after acceptance with registered addr/data.
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [20:0] req_imm,
    input  logic        req_last,
    output logic        imem_we,
    output logic [7:0]  imem_addr,
    output logic [31:0] imem_wdata,
    output logic        busy,
    output logic        done,
    output logic [2:0]  err,
    output logic [8:0]  instr_count
);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    localparam logic [2:0] OpAdd  = 3'd0;
    localparam logic [2:0] OpSub  = 3'd1;
    localparam logic [2:0] OpAddi = 3'd2;
    localparam logic [2:0] OpBne  = 3'd3;
    localparam logic [2:0] OpJal  = 3'd4;

    localparam logic [8:0] MemWords = 9'd256;

    state_e      state_q, state_d;
    logic [7:0]  wptr_q, wptr_d;
    logic [8:0]  count_q, count_d;
    logic [2:0]  err_q, err_d;
    logic        we_q, we_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        done_q, done_d;

    logic        op_legal;
    logic        imm_ok;
    logic        mem_full;
    logic [31:0] enc_word;

    assign op_legal = (req_op <= OpJal);
    assign mem_full = (count_q == MemWords);

    // Range test: the upper bits must be a pure sign extension of the encodable field.
    always_comb begin
        imm_ok = 1'b1;
        case (req_op)
            OpAddi:  imm_ok = (&req_imm[20:11]) || !(|req_imm[20:11]);
            OpBne:   imm_ok = !req_imm[0] && ((&req_imm[20:12]) || !(|req_imm[20:12]));
            OpJal:   imm_ok = !req_imm[0];
            default: imm_ok = 1'b1;
        endcase
    end

    always_comb begin
        enc_word = 32'd0;
        case (req_op)
            OpAdd:   enc_word = {7'b0000000, req_rs2, req_rs1, 3'b000, req_rd, 7'b0110011};
            OpSub:   enc_word = {7'b0100000, req_rs2, req_rs1, 3'b000, req_rd, 7'b0110011};
            OpAddi:  enc_word = {req_imm[11:0], req_rs1, 3'b000, req_rd, 7'b0010011};
            OpBne:   enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b001,
                                 req_imm[4:1], req_imm[11], 7'b1100011};
            OpJal:   enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                                 req_rd, 7'b1101111};
            default: enc_word = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StLoad;
                    wptr_d  = 8'd0;
                    count_d = 9'd0;
                    err_d   = 3'b000;
                    addr_d  = 8'd0;
                end
            end
            StLoad: begin
                if (req_valid) begin
                    if (!op_legal) begin
                        err_d[0] = 1'b1;
                    end else begin
                        if (!imm_ok) err_d[1] = 1'b1;
                        if (mem_full) err_d[2] = 1'b1;
                        if (imm_ok && !mem_full) begin
                            we_d    = 1'b1;
                            addr_d  = wptr_q;
                            wdata_d = enc_word;
                            count_d = count_q + 9'd1;
                            // Pointer saturates at the top word; the full check blocks later writes.
                            if (wptr_q != 8'hff) wptr_d = wptr_q + 8'd1;
                        end
                    end
                    if (req_last) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            wptr_q  <= 8'd0;
            count_q <= 9'd0;
            err_q   <= 3'b000;
            we_q    <= 1'b0;
            addr_q  <= 8'd0;
            wdata_q <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign req_ready   = (state_q == StLoad);
    assign busy        = (state_q == StLoad);
    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign done        = done_q;
    assign err         = err_q;
    assign instr_count = count_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 start  in  1  pulse; begins a program load at word address 0.
REQ-004 req_valid  in  1  instruction request valid.
REQ-005 req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
REQ-006 req_op  in  3  request opcode: 0 ADD, 1 SUB, 2 ADDI, 3 BNE, 4 JAL; values 5-7 are illegal.
REQ-007 req_rd, req_rs1, req_rs2  in  5 each  register indices.
REQ-008 req_imm  in  21  signed byte offset or immediate.
REQ-009 req_last  in  1  marks the final request of the program.
REQ-010 imem_we  out  1  instruction-memory write strobe.
REQ-011 imem_addr  out  8  word address.
REQ-012 imem_wdata  out  32  encoded RV32I word.
REQ-013 busy  out  1  high in LOAD state.
REQ-014 done  out  1  one-cycle pulse at load completion.
REQ-015 err  out  3  sticky error flags: [0] illegal op, [1] immediate range or alignment, [2] memory full.
REQ-016 instr_count  out  9  number of words written in the current load.

Function
REQ-017 FSM states: IDLE, LOAD, DONE.
- IDLE or DONE with start -> LOAD; also clears address, instr_count and err.
- start while in LOAD is ignored.
REQ-018 req_ready = (state == LOAD); no request is accepted in IDLE or DONE.
REQ-019 Encoding, with funct fields matching the core's decoder:
- ADD: {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011}.
- SUB: as ADD with funct7 = 7'b0100000.
- ADDI: {imm[11:0], rs1, 3'b000, rd, 7'b0010011}.
- BNE: {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011}.
- JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111}.
REQ-020 Legal immediate ranges:
- ADDI: -2048..2047.
- BNE: -4096..4094, even only.
- JAL: -1048576..1048574, even only.
- ADD and SUB: req_imm is ignored.
REQ-021 Latency: request accepted in cycle N -> imem_we = 1 in cycle N+1, with registered addr/wdata; sustained throughput is 1 word/cycle.
REQ-022 After each write: imem_addr increments by 1 and instr_count increments by 1; imem_addr never wraps past 255.
REQ-023 Rejected requests are consumed but produce no write and no address increment; each sets the relevant err bit:
- illegal op sets err[0].
- immediate out of range or odd sets err[1].
- request accepted when instr_count == 256 sets err[2].
REQ-024 err bits are OR-accumulated and hold until the next start or rst.
REQ-025 Accepted request with req_last = 1: in cycle N+1 the last write (if legal) occurs, done = 1, and the state moves to DONE. A rejected last request still ends the load.
REQ-026 imem_we is low in every cycle without a legal accepted request in the prior cycle.
REQ-027 Simultaneous start and rst: rst wins.

Reset
REQ-028 rst -> state IDLE; req_ready, imem_we, busy and done = 0; imem_addr = 0; imem_wdata = 0; err = 0; instr_count = 0.
REQ-029 rst during LOAD aborts the load immediately; a write pending from the prior cycle is suppressed.

Verification
REQ-030 start; then ADDI rd=1 rs1=0 imm=1, ADD rd=3 rs1=1 rs2=2, SUB rd=3 rs1=1 rs2=2 (last) -> writes at addr 0/1/2 of 0x00100093, 0x002081B3, 0x402081B3 on consecutive cycles; done pulses with the third write; instr_count = 3.
REQ-031 BNE rs1=1 rs2=2 imm=-8 -> 0xFE209CE3; JAL rd=0 imm=-8 -> 0xFF9FF06F.
REQ-032 Error requests:
- ADDI imm=2048 -> no write, err = 3'b010, next legal request written at the unchanged address.
- BNE imm=3 -> err[1] set.
- op=6 -> err[0] set.
REQ-033 256 legal requests, then a 257th -> addresses 0..255 written, 257th dropped, err[2] = 1, instr_count = 256.
REQ-034 rst asserted mid-load after 5 writes -> all outputs at reset values next cycle; a following start reloads from addr 0.
REQ-035 start in LOAD ignored; start in DONE clears err and instr_count and reloads from addr 0; req_valid held high in IDLE -> req_ready = 0, no writes.
